addsub_seq: RTL and testbench

Multi-precision add/subtract sequencer. Drives one external 16-bit ripple adder (a, b, cin -> s, cout) over WORDS consecutive cycles, least-significant limb first, and chains each limb's carry-out into the next limb's carry-in. Produces a WORDS*16-bit sum or difference with carry/borrow and signed overflow. Sits between a requesting datapath and the shared adder16 instance.

---
 rtl/addsub_seq_if.sv | 26 ++
 rtl/addsub_seq.sv | 104 ++++++++++
 tb/tb_addsub_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_if.sv
// Request/response bundle between a requesting datapath and the
// multi-precision add/subtract sequencer.
interface addsub_seq_if #(
    parameter int W     = 16,
    parameter int WORDS = 4
);
    logic               start;
    logic               sub;
    logic [W*WORDS-1:0] a;
    logic [W*WORDS-1:0] b;
    logic               busy;
    logic               done;
    logic [W*WORDS-1:0] result;
    logic               cout;
    logic               overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/addsub_seq.sv
// Multi-precision add/subtract sequencer. Walks one shared W-bit adder
// over WORDS limbs, LSB limb first, chaining carry between limbs.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; adder lanes driven 0; last result held
// RUN   | one limb per cycle through the external adder, k = 0..WORDS-1
// DONE  | single-cycle done pulse; result/cout/overflow valid
module addsub_seq #(
    parameter int W     = 16,
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    addsub_seq_if.slave  req,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_cin,
    input  logic [W-1:0] add_s,
    input  logic         add_cout
);
    localparam int N  = W * WORDS;
    localparam int KW = $clog2(WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [KW-1:0] k;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic          sub_reg;
    logic          carry;
    logic [N-1:0]  result_r;
    logic          cout_r;
    logic          ovf_r;
    logic          last_limb;
    logic          beff_msb;

    assign last_limb = (k == KW'(WORDS - 1));
    // Sign bit of the effective B operand (inverted when subtracting).
    assign beff_msb  = b_reg[N-1] ^ sub_reg;

    // Adder lanes: current limb of A, B (conditionally inverted), chained carry.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[k*W +: W];
            add_b   = b_reg[k*W +: W] ^ {W{sub_reg}};
            add_cin = (k == '0) ? sub_reg : carry;
        end
    end

    // Sequencer state, operand capture and per-limb result collection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            sub_reg  <= 1'b0;
            carry    <= 1'b0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req.start) begin
                        a_reg    <= req.a;
                        b_reg    <= req.b;
                        sub_reg  <= req.sub;
                        k        <= '0;
                        result_r <= '0;
                        cout_r   <= 1'b0;
                        ovf_r    <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result_r[k*W +: W] <= add_s;
                    carry              <= add_cout;
                    k                  <= k + 1'b1;
                    if (last_limb) begin
                        cout_r <= add_cout;
                        ovf_r  <= (a_reg[N-1] == beff_msb) && (add_s[W-1] != a_reg[N-1]);
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req.busy     = (state == RUN) || (state == DONE);
    assign req.done     = (state == DONE);
    assign req.result   = result_r;
    assign req.cout     = cout_r;
    assign req.overflow = ovf_r;
endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq with a behavioural 16-bit adder attached.
module tb_addsub_seq;
    localparam int W     = 16;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;

    logic         clk;
    logic         rst;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_s;
    logic         add_cout;

    int n_tests;
    int n_fail;

    addsub_seq_if #(.W(W), .WORDS(WORDS)) req ();

    addsub_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // External ripple adder stand-in.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request at a negedge and follows it until done or timeout.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                          output logic [N-1:0] res, output logic c, output logic o,
                          output int lat, output logic [N-1:0] res_k0,
                          output logic [W-1:0] a_k0, output logic cin_k0);
        @(negedge clk);
        req.a     = a;
        req.b     = b;
        req.sub   = sub;
        req.start = 1'b1;
        lat       = -1;
        res_k0    = '1;
        a_k0      = '1;
        cin_k0    = 1'bx;
        for (int cnt = 1; cnt <= 20; cnt++) begin
            @(negedge clk);
            if (cnt == 1) begin
                req.start = 1'b0;
                res_k0    = req.result;
                a_k0      = add_a;
                cin_k0    = add_cin;
            end
            if (req.done) begin
                lat = cnt;
                break;
            end
        end
        res = req.result;
        c   = req.cout;
        o   = req.overflow;
    endtask

    task automatic check_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic sub, input logic [N-1:0] er, input logic ec,
                            input logic eo);
        logic [N-1:0] res;
        logic [N-1:0] res_k0;
        logic [W-1:0] a_k0;
        logic         c;
        logic         o;
        logic         cin_k0;
        int           lat;
        run_op(a, b, sub, res, c, o, lat, res_k0, a_k0, cin_k0);
        n_tests++;
        if (lat !== WORDS + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, WORDS + 1);
        end
        n_tests++;
        if (res !== er) begin
            n_fail++;
            $display("FAIL %s result: got %h expected %h", name, res, er);
        end
        n_tests++;
        if (c !== ec) begin
            n_fail++;
            $display("FAIL %s cout: got %b expected %b", name, c, ec);
        end
        n_tests++;
        if (o !== eo) begin
            n_fail++;
            $display("FAIL %s overflow: got %b expected %b", name, o, eo);
        end
        n_tests++;
        if (res_k0 !== '0 || a_k0 !== a[W-1:0] || cin_k0 !== sub) begin
            n_fail++;
            $display("FAIL %s first_limb: result %h add_a %h cin %b expected 0 %h %b",
                     name, res_k0, a_k0, cin_k0, a[W-1:0], sub);
        end
        @(negedge clk);
        n_tests++;
        if (req.done !== 1'b0 || req.busy !== 1'b0 || req.result !== er) begin
            n_fail++;
            $display("FAIL %s after_done: done %b busy %b result %h expected 0 0 %h",
                     name, req.done, req.busy, req.result, er);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req.start = 1'b0;
        req.sub   = 1'b1;
        req.a     = 64'h1234_5678_9ABC_DEF0;
        req.b     = 64'h0FED_CBA9_8765_4321;
        repeat (2) @(negedge clk);
        n_tests++;
        if (req.busy !== 1'b0 || req.done !== 1'b0 || req.result !== '0 ||
            req.cout !== 1'b0 || req.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy %b done %b result %h cout %b ovf %b expected all 0",
                     req.busy, req.done, req.result, req.cout, req.overflow);
        end
        n_tests++;
        if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_adder: add_a %h add_b %h cin %b expected 0", add_a, add_b, add_cin);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req.busy !== 1'b0 || add_b !== '0) begin
            n_fail++;
            $display("FAIL idle_no_start: busy %b add_b %h expected 0 0", req.busy, add_b);
        end
    endtask

    task automatic test_add_carry();
        check_op("add_carry", 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0C45, 1'b0,
                 64'h0000_0000_0001_0C44, 1'b0, 1'b0);
    endtask

    task automatic test_sub_no_borrow();
        check_op("sub_no_borrow", 64'h0000_0000_0000_FC43, 64'h0000_0000_0000_0983, 1'b1,
                 64'h0000_0000_0000_F2C0, 1'b1, 1'b0);
    endtask

    task automatic test_borrow_wrap();
        check_op("borrow_wrap", 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic test_carry_chain();
        check_op("carry_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_signed_overflow();
        check_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        check_op("ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 1'b1,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    endtask

    task automatic test_start_ignored();
        int busy_cycles;
        int done_cnt;
        @(negedge clk);
        req.a     = 64'h0000_0001_0000_0001;
        req.b     = 64'h0000_0002_0000_0002;
        req.sub   = 1'b0;
        req.start = 1'b1;
        busy_cycles = 0;
        done_cnt    = 0;
        for (int cnt = 1; cnt <= 10; cnt++) begin
            @(negedge clk);
            if (cnt == 1) req.start = 1'b0;
            if (cnt == 2) begin
                req.start = 1'b1;
                req.sub   = 1'b1;
                req.a     = 64'hAAAA_BBBB_CCCC_DDDD;
                req.b     = 64'h1111_2222_3333_4444;
            end
            if (cnt == 3) begin
                req.start = 1'b0;
                req.a     = 64'h5555_5555_5555_5555;
            end
            if (req.busy) busy_cycles++;
            if (req.done) done_cnt++;
        end
        n_tests++;
        if (busy_cycles !== WORDS + 1) begin
            n_fail++;
            $display("FAIL ignore_busy_len: got %0d expected %0d", busy_cycles, WORDS + 1);
        end
        n_tests++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d expected 1", done_cnt);
        end
        n_tests++;
        if (req.result !== 64'h0000_0003_0000_0003 || req.cout !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_result: got %h cout %b expected 0000000300000003 0",
                     req.result, req.cout);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_cnt;
        @(negedge clk);
        req.a     = 64'h0000_0000_0000_1111;
        req.b     = 64'h0000_0000_0000_2222;
        req.sub   = 1'b0;
        req.start = 1'b1;
        @(negedge clk);
        req.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        n_tests++;
        if (req.busy !== 1'b0 || req.result !== '0 || req.done !== 1'b0 || add_a !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_run: busy %b result %h done %b add_a %h expected 0",
                     req.busy, req.result, req.done, add_a);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req.done || req.busy) done_cnt++;
        end
        n_tests++;
        if (done_cnt !== 0) begin
            n_fail++;
            $display("FAIL rst_no_done: activity cycles %0d expected 0", done_cnt);
        end
        check_op("after_rst", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
                 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_add_carry();
        test_sub_no_borrow();
        test_borrow_wrap();
        test_carry_chain();
        test_signed_overflow();
        test_start_ignored();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
